fifo_burst_reader: RTL and testbench

//  Read-side master for synch_fifo. On start_i it pops exactly len_i words.
//  It only pops when the FIFO is non-empty and its own buffer has room.

---
 rtl/fifo_burst_reader.sv | 90 +++++++++
 tb/tb_fifo_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from synch_fifo through a 2-entry skid buffer
// and presents it as a valid/ready stream with last/done markers.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_underflow_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_iss_cnt, r_out_cnt;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
  logic [1:0]            r_occ;
  logic                  r_pend, r_err;
  logic                  w_xfer, w_pop;
  logic [2:0]            w_fill;
  assign w_xfer = m_valid_o & m_ready_i;
  // Occupancy projected one cycle ahead: a word in flight needs a free slot when it lands.
  assign w_fill = {1'b0, r_occ} + {2'b0, r_pend} - {2'b0, w_xfer};
  assign w_pop  = (r_state == RUN) & (r_iss_cnt != '0) & ~fifo_empty_i & (w_fill < 3'd2);
  assign fifo_rd_en_o = w_pop;
  assign busy_o    = r_state != IDLE;
  assign done_o    = r_state == DONE;
  assign err_o     = r_err;
  assign m_valid_o = r_occ != 2'd0;
  assign m_data_o  = r_buf0;
  assign m_last_o  = m_valid_o & (r_out_cnt == LEN_WIDTH'(1));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_i ? ((len_i != '0) ? RUN : DONE) : IDLE;
      RUN:     w_next = (w_pop && r_iss_cnt == LEN_WIDTH'(1)) ? DRAIN : RUN;
      DRAIN:   w_next = (w_xfer && r_out_cnt == LEN_WIDTH'(1)) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_iss_cnt <= '0;
      r_out_cnt <= '0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_occ     <= 2'd0;
      r_pend    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pop;
      r_err   <= r_err | fifo_underflow_i;
      if (r_state == IDLE && start_i) begin
        r_iss_cnt <= len_i;
        r_out_cnt <= len_i;
      end else begin
        if (w_pop) r_iss_cnt <= r_iss_cnt - LEN_WIDTH'(1);
        if (w_xfer) r_out_cnt <= r_out_cnt - LEN_WIDTH'(1);
      end
      // Capture and drain together leave occupancy unchanged; the new word goes behind the survivor.
      if (r_pend && w_xfer) begin
        if (r_occ == 2'd2) begin
          r_buf0 <= r_buf1;
          r_buf1 <= fifo_rdata_i;
        end else begin
          r_buf0 <= fifo_rdata_i;
        end
      end else if (r_pend) begin
        if (r_occ == 2'd0) r_buf0 <= fifo_rdata_i;
        else r_buf1 <= fifo_rdata_i;
        r_occ <= r_occ + 2'd1;
      end else if (w_xfer) begin
        r_buf0 <= r_buf1;
        r_occ  <= r_occ - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized bench; a queue stands in for synch_fifo and the expected
// stream is simply the words written into it, consumed in order, len at a time.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, underflow = 1'b0, m_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic busy, done, err, rd_en, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  int nvec = 0, nerr = 0;
  int ready_pct = 100, push_pct = 0;
  logic [DW-1:0] q[$], ref_q[$], src[$], exp_d[$];
  int epoch = 0, seen = 0, cyc = 0;
  int n_pops = 0, pop_first = 0, pop_last = 0, n_bad_pop = 0, n_done = 0, done_cyc = 0;
  int n_busy = 0, n_valid = 0, n_hold = 0, n_badlast = 0;
  logic [DW-1:0] obs_d[$];
  logic obs_l[$];
  int obs_c[$];
  logic hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .busy_o(busy), .done_o(done),
    .err_o(err), .fifo_rd_en_o(rd_en), .fifo_rdata_i(fifo_rdata), .fifo_empty_i(fifo_empty),
    .fifo_underflow_i(underflow), .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last),
    .m_ready_i(m_ready));

  // FIFO model: read data appears the cycle after the pop, writes become visible one edge later.
  always @(posedge clk) begin
    if (rd_en && !fifo_empty && q.size() > 0) fifo_rdata <= q.pop_front();
    fifo_empty <= (q.size() == 0);
  end

  always @(negedge clk) begin
    if (epoch != seen) begin
      seen = epoch; n_pops = 0; pop_first = 0; pop_last = 0; n_bad_pop = 0; n_done = 0;
      done_cyc = 0; n_busy = 0; n_valid = 0; n_hold = 0; n_badlast = 0; hold_prev = 1'b0;
      obs_d.delete(); obs_l.delete(); obs_c.delete();
    end
    cyc++;
    if (rd_en) begin
      if (n_pops == 0) pop_first = cyc;
      pop_last = cyc;
      n_pops++;
    end
    if (rd_en && fifo_empty) n_bad_pop++;
    if (m_last && !m_valid) n_badlast++;
    if (m_valid && m_ready) begin
      obs_d.push_back(m_data); obs_l.push_back(m_last); obs_c.push_back(cyc);
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) n_busy++;
    if (m_valid) n_valid++;
    if (hold_prev && (!m_valid || m_data !== hold_data)) n_hold++;
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
  end

  task automatic step();
    @(posedge clk); #1;
    m_ready = (int'($urandom_range(99)) < ready_pct);
    if (src.size() > 0 && int'($urandom_range(99)) < push_pct) q.push_back(src.pop_front());
  endtask

  task automatic preload(input logic [DW-1:0] w);
    q.push_back(w); ref_q.push_back(w);
  endtask

  task automatic plan(input logic [DW-1:0] w);
    src.push_back(w); ref_q.push_back(w);
  endtask

  task automatic start_burst(input int l);
    exp_d.delete();
    for (int i = 0; i < l; i++) exp_d.push_back(ref_q.pop_front());
    epoch++;
    start = 1'b1; len = LW'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    for (int i = 0; i < budget && n_done == 0; i++) step();
    ok = n_done > 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; underflow = 1'b0;
    q.delete(); ref_q.delete(); src.delete();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ready_pct = 100;
    rst = 1'b1; underflow = 1'b1;
    step(); step();
    nvec++; if ({busy, done, err, rd_en, m_valid, m_last, m_data} !== '0) begin nerr++;
      $display("FAIL reset_outputs got %h exp 0", {busy, done, err, rd_en, m_valid, m_last, m_data}); end
    underflow = 1'b0; rst = 1'b0;
    step(); step();
    nvec++; if ({busy, done, err, rd_en, m_valid} !== '0) begin nerr++;
      $display("FAIL reset_idle got %b exp 0", {busy, done, err, rd_en, m_valid}); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    ready_pct = 100; push_pct = 0;
    preload(8'h11); preload(8'h22); preload(8'h33); preload(8'h44);
    step();
    start_burst(4);
    wait_done(40, ok);
    step(); step();
    nvec++; if (!ok) begin nerr++; $display("FAIL basic_done_timeout got 0 exp 1"); end
    nvec++; if (n_pops !== 4 || pop_last - pop_first !== 3) begin nerr++;
      $display("FAIL basic_pops got %0d over %0d cycles exp 4 over 4", n_pops, pop_last - pop_first + 1); end
    nvec++; if (obs_d.size() !== 4) begin nerr++; $display("FAIL basic_count got %0d exp 4", obs_d.size()); end
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      nvec++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 3)) begin nerr++;
        $display("FAIL basic_word%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_d[i], i == 3); end
    end
    if (obs_c.size() == 4) begin
      nvec++; if (obs_c[0] !== pop_first + 2 || obs_c[3] - obs_c[0] !== 3) begin nerr++;
        $display("FAIL basic_timing got first %0d span %0d exp %0d span 3", obs_c[0], obs_c[3] - obs_c[0], pop_first + 2); end
      nvec++; if (n_done !== 1 || done_cyc !== obs_c[3] + 1) begin nerr++;
        $display("FAIL basic_done got %0d at %0d exp 1 at %0d", n_done, done_cyc, obs_c[3] + 1); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    push_pct = 0;
    for (int i = 0; i < 5; i++) preload(DW'($urandom));
    ready_pct = 0;
    step();
    start_burst(3);
    for (int i = 0; i < 10; i++) step();
    nvec++; if (n_pops !== 2 || obs_d.size() !== 0) begin nerr++;
      $display("FAIL bp_stall got pops %0d xfers %0d exp 2 0", n_pops, obs_d.size()); end
    nvec++; if (m_valid !== 1'b1 || m_data !== exp_d[0] || n_hold !== 0) begin nerr++;
      $display("FAIL bp_hold got %b/%h viol %0d exp 1/%h viol 0", m_valid, m_data, n_hold, exp_d[0]); end
    ready_pct = 100;
    wait_done(40, ok);
    nvec++; if (!ok || n_pops !== 3 || q.size() !== 2) begin nerr++;
      $display("FAIL bp_finish got done %0d pops %0d left %0d exp 1 3 2", ok, n_pops, q.size()); end
    nvec++; if (obs_d.size() !== 3) begin nerr++; $display("FAIL bp_count got %0d exp 3", obs_d.size()); end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      nvec++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 2)) begin nerr++;
        $display("FAIL bp_word%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_d[i], i == 2); end
    end
  endtask

  task automatic test_starved();
    do_reset();
    ready_pct = 100; push_pct = 0;
    plan(DW'($urandom)); plan(DW'($urandom));
    start_burst(2);
    for (int i = 0; i < 40 && n_done == 0; i++) begin
      if (i % 4 == 3 && src.size() > 0) q.push_back(src.pop_front());
      step();
    end
    step();
    nvec++; if (n_done !== 1 || n_pops !== 2 || n_bad_pop !== 0) begin nerr++;
      $display("FAIL starve_ctrl got done %0d pops %0d bad %0d exp 1 2 0", n_done, n_pops, n_bad_pop); end
    nvec++; if (obs_d.size() !== 2) begin nerr++; $display("FAIL starve_count got %0d exp 2", obs_d.size()); end
    for (int i = 0; i < 2 && i < obs_d.size(); i++) begin
      nvec++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 1)) begin nerr++;
        $display("FAIL starve_word%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_d[i], i == 1); end
    end
  endtask

  task automatic test_zero_len();
    ready_pct = 100;
    preload(DW'($urandom)); preload(DW'($urandom));
    step();
    start_burst(0);
    for (int i = 0; i < 6; i++) step();
    nvec++; if (n_pops !== 0 || n_valid !== 0) begin nerr++;
      $display("FAIL zero_quiet got pops %0d valid %0d exp 0 0", n_pops, n_valid); end
    nvec++; if (n_busy !== 1 || n_done !== 1) begin nerr++;
      $display("FAIL zero_pulse got busy %0d done %0d exp 1 1", n_busy, n_done); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ready_pct = 100; push_pct = 0;
    for (int i = 0; i < 5; i++) preload(DW'($urandom));
    step();
    start_burst(5);
    for (int i = 0; i < 30 && obs_d.size() < 2; i++) step();
    nvec++; if (obs_d.size() < 2) begin nerr++; $display("FAIL mid_progress got %0d exp 2", obs_d.size()); end
    rst = 1'b1;
    step();
    nvec++; if ({busy, done, err, rd_en, m_valid, m_last, m_data} !== '0) begin nerr++;
      $display("FAIL mid_reset got %h exp 0", {busy, done, err, rd_en, m_valid, m_last, m_data}); end
    q.delete(); ref_q.delete();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) preload(DW'($urandom));
    step();
    start_burst(3);
    wait_done(40, ok);
    nvec++; if (!ok || obs_d.size() !== 3) begin nerr++;
      $display("FAIL mid_restart got done %0d words %0d exp 1 3", ok, obs_d.size()); end
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      nvec++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == 2)) begin nerr++;
        $display("FAIL mid_word%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_d[i], i == 2); end
    end
  endtask

  task automatic test_underflow();
    bit ok;
    do_reset();
    ready_pct = 100; push_pct = 0;
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL err_initial got %b exp 0", err); end
    underflow = 1'b1;
    step();
    underflow = 1'b0;
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL err_set got %b exp 1", err); end
    preload(DW'($urandom)); preload(DW'($urandom));
    step();
    start_burst(2);
    wait_done(40, ok);
    nvec++; if (!ok || err !== 1'b1 || obs_d.size() !== 2) begin nerr++;
      $display("FAIL err_sticky got done %0d err %b words %0d exp 1 1 2", ok, err, obs_d.size()); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL err_clear got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int l, pre;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      l = int'($urandom_range(1, 12));
      pre = int'($urandom_range(0, l));
      ready_pct = int'($urandom_range(30, 100));
      push_pct = int'($urandom_range(30, 100));
      while (src.size() > 0) q.push_back(src.pop_front());
      for (int i = 0; i < pre; i++) preload(DW'($urandom));
      for (int i = 0; i < l - pre + int'($urandom_range(0, 2)); i++) plan(DW'($urandom));
      start_burst(l);
      wait_done(400, ok);
      step();
      nvec++; if (!ok || n_done !== 1) begin nerr++;
        $display("FAIL b2b%0d_done got %0d/%0d exp 1/1", it, ok, n_done); end
      nvec++; if (n_pops !== l || n_bad_pop !== 0 || n_hold !== 0 || n_badlast !== 0) begin nerr++;
        $display("FAIL b2b%0d_proto got pops %0d bad %0d hold %0d last %0d exp %0d 0 0 0",
                 it, n_pops, n_bad_pop, n_hold, n_badlast, l); end
      nvec++; if (obs_d.size() !== l) begin nerr++;
        $display("FAIL b2b%0d_count got %0d exp %0d", it, obs_d.size(), l); end
      for (int i = 0; i < l && i < obs_d.size(); i++) begin
        nvec++; if (obs_d[i] !== exp_d[i] || obs_l[i] !== (i == l - 1)) begin nerr++;
          $display("FAIL b2b%0d_word%0d got %h/%b exp %h/%b", it, i, obs_d[i], obs_l[i], exp_d[i], i == l - 1); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starved();
    test_zero_len();
    test_reset_mid();
    test_underflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
